level_sequencer: RTL and testbench
==================================

LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 Parameter TIME_LIMIT, default 60, seconds allowed per level attempt (1..255).
REQ-002 Parameter LIVES, default 3, wrong letters tolerated before failure (1..3).
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 practice  input  1  mode switch, highest priority.
REQ-006 lvl_sw  input  3  level switches {lvl_3,lvl_2,lvl_1}; priority lvl_1 > lvl_2 > lvl_3.
REQ-007 letter_valid  input  1  one-cycle pulse: decoded Morse letter available.
REQ-008 letter  input  8  ASCII uppercase letter, valid when letter_valid=1.
REQ-009 sec_tick  input  1  one-cycle pulse once per second.
REQ-010 page_sel  output  3  display page: 0 START, 1 PRACTICE, 2 LVL1, 3 LVL2, 4 LVL3, 5 DONE, 6 FAIL.
REQ-011 letter_idx  output  4  count of correct letters so far (practice: letters entered, mod 16).
REQ-012 lives_left  output  2  remaining lives.
REQ-013 time_left  output  8  seconds remaining in current attempt.
REQ-014 level_won  output  1  one-cycle pulse on entry to DONE.

Function
REQ-015 States: START, PRACTICE, PLAY, DONE, FAIL; active level held in a 2-bit register (1..3); page_sel is a registered decode of state and level.
REQ-016 Requested mode = PRACTICE if practice=1, else first set bit of lvl_sw by priority, else START.
REQ-017 START/PRACTICE/PLAY: when requested mode differs from the current one, next cycle enter the requested mode, idx=0, lives_left=LIVES, time_left=TIME_LIMIT.
REQ-018 DONE/FAIL: hold until requested mode changes; all switches off -> START; any other change -> that mode, freshly initialised as in REQ-017.
REQ-019 PRACTICE: each letter_valid increments letter_idx (wraps 15->0); no checking; time_left/lives_left frozen.
REQ-020 PLAY: letter_valid compares letter with target char at letter_idx from the word ROM in the same cycle; result registered at next edge.
REQ-021 Match and letter_idx = len-1 -> DONE, level_won=1 for one cycle, letter_idx=len.
REQ-022 Match otherwise -> letter_idx+1.
REQ-023 Mismatch -> letter_idx=0; lives_left-1; if lives_left was 1 -> FAIL, lives_left=0.
REQ-024 PLAY: sec_tick decrements time_left; sec_tick with time_left=1 -> time_left=0, FAIL.
REQ-025 Simultaneous letter_valid and sec_tick: letter evaluated first; completing match -> DONE (time_left keeps pre-tick value); otherwise both effects apply, FAIL on either condition.
REQ-026 letter_valid/sec_tick ignored in START, DONE, FAIL; letter_valid with non-letter code counts as mismatch in PLAY.
REQ-027 Switch change has priority over letter/tick in the same cycle.

Reset
REQ-028 reset overrides all: state=START, page_sel=0, letter_idx=0, lives_left=LIVES, time_left=TIME_LIMIT, level_won=0, takes effect at the next edge, including mid-PLAY.

Structure
REQ-029 Shared package holds page_sel encodings, state encodings, target words (L1 "SOS", L2 "HELP", L3 "ESCAPE"), and MAX_LEN=8.
REQ-030 One sub-module word_rom: combinational, inputs level and index, outputs char and length.

Verification
REQ-031 lvl_1=1, letters S,O,S -> letter_idx 1,2,3, level_won pulse once, page_sel=5.
REQ-032 lvl_2=1, letters H,X -> letter_idx 0, lives_left=2; two more wrong letters -> page_sel=6, lives_left=0.
REQ-033 lvl_3=1, TIME_LIMIT=3, three sec_ticks with no letters -> time_left 2,1,0, page_sel=6.
REQ-034 Level 1 at idx 2, time_left=1, final S and sec_tick same cycle -> page_sel=5, time_left=1.
REQ-035 PLAY mid-word, assert practice -> page_sel=1, letter_idx=0; 17 letters -> letter_idx=1.
REQ-036 reset during PLAY at idx 2 -> next cycle page_sel=0, letter_idx=0, lives_left=3, time_left=60.

Source files
------------

// File: rtl/level_sequencer_pkg.sv
// rtl/level_sequencer_pkg.sv - shared encodings, target words and decode helpers
package level_sequencer_pkg;

   localparam int MAX_LEN = 8;

   typedef enum logic [2:0] {
      PAGE_START    = 3'd0,
      PAGE_PRACTICE = 3'd1,
      PAGE_LVL1     = 3'd2,
      PAGE_LVL2     = 3'd3,
      PAGE_LVL3     = 3'd4,
      PAGE_DONE     = 3'd5,
      PAGE_FAIL     = 3'd6
   } page_e;

   typedef enum logic [2:0] {
      ST_START,
      ST_PRACTICE,
      ST_PLAY,
      ST_DONE,
      ST_FAIL
   } state_e;

   // Words are right-justified: first letter in the most significant used byte.
   localparam logic [8*MAX_LEN-1:0] WORD_L1 = {40'd0, "SOS"};
   localparam logic [8*MAX_LEN-1:0] WORD_L2 = {32'd0, "HELP"};
   localparam logic [8*MAX_LEN-1:0] WORD_L3 = {16'd0, "ESCAPE"};
   localparam logic [3:0] LEN_L1 = 4'd3;
   localparam logic [3:0] LEN_L2 = 4'd4;
   localparam logic [3:0] LEN_L3 = 4'd6;

   function automatic page_e level_page(input logic [1:0] lvl);
      case (lvl)
         2'd2:    return PAGE_LVL2;
         2'd3:    return PAGE_LVL3;
         default: return PAGE_LVL1;
      endcase
   endfunction

   // The mode a state belongs to; DONE/FAIL still belong to the level that produced them.
   function automatic page_e mode_page(input state_e st, input logic [1:0] lvl);
      case (st)
         ST_START:    return PAGE_START;
         ST_PRACTICE: return PAGE_PRACTICE;
         default:     return level_page(lvl);
      endcase
   endfunction

   function automatic page_e page_decode(input state_e st, input logic [1:0] lvl);
      case (st)
         ST_DONE: return PAGE_DONE;
         ST_FAIL: return PAGE_FAIL;
         default: return mode_page(st, lvl);
      endcase
   endfunction

endpackage

// File: rtl/level_sequencer_if.sv
// rtl/level_sequencer_if.sv - switch/letter/tick inputs and display outputs bundle
interface level_sequencer_if;
   logic       practice;
   logic [2:0] lvl_sw;
   logic       letter_valid;
   logic [7:0] letter;
   logic       sec_tick;
   logic [2:0] page_sel;
   logic [3:0] letter_idx;
   logic [1:0] lives_left;
   logic [7:0] time_left;
   logic       level_won;

   modport master (
      output practice, lvl_sw, letter_valid, letter, sec_tick,
      input  page_sel, letter_idx, lives_left, time_left, level_won
   );

   modport slave (
      input  practice, lvl_sw, letter_valid, letter, sec_tick,
      output page_sel, letter_idx, lives_left, time_left, level_won
   );
endinterface

// File: rtl/level_sequencer_word_rom.sv
// rtl/level_sequencer_word_rom.sv - combinational target word lookup
module word_rom
   import level_sequencer_pkg::*;
(
   input  logic [1:0] level,
   input  logic [3:0] index,
   output logic [7:0] target_char,
   output logic [3:0] length
);

   logic [8*MAX_LEN-1:0] word;
   logic [2:0]           pos;

   // Select the word for the level and pick the letter at index; out-of-range gives 0.
   always_comb begin
      case (level)
         2'd1: begin word = WORD_L1; length = LEN_L1; end
         2'd2: begin word = WORD_L2; length = LEN_L2; end
         2'd3: begin word = WORD_L3; length = LEN_L3; end
         default: begin word = '0; length = 4'd0; end
      endcase
      pos = 3'(length - 4'd1 - index);
      target_char = (index < length) ? word[{pos, 3'b000} +: 8] : 8'h00;
   end

endmodule

// File: rtl/level_sequencer.sv
// rtl/level_sequencer.sv - game mode sequencer: practice, timed levels, done/fail pages
module level_sequencer
   import level_sequencer_pkg::*;
#(
   parameter int TIME_LIMIT = 60,
   parameter int LIVES      = 3
)
(
   input logic               clk,
   input logic               reset,
   level_sequencer_if.slave  bus
);

   localparam logic [7:0] TIME_INIT  = TIME_LIMIT[7:0];
   localparam logic [1:0] LIVES_INIT = LIVES[1:0];

   state_e     state_q, state_d;
   page_e      page_q;
   page_e      req_page;
   logic [1:0] level_q, level_d;
   logic [3:0] idx_q, idx_d;
   logic [1:0] lives_q, lives_d;
   logic [7:0] time_q, time_d;
   logic       won_q, won_d;
   logic       finished;
   logic [7:0] rom_char;
   logic [3:0] rom_len;

   word_rom u_word_rom (
      .level       (level_q),
      .index       (idx_q),
      .target_char (rom_char),
      .length      (rom_len)
   );

   // Requested mode from the switches: practice first, then lowest numbered level.
   always_comb begin
      req_page = PAGE_START;
      if (bus.practice)       req_page = PAGE_PRACTICE;
      else if (bus.lvl_sw[0]) req_page = PAGE_LVL1;
      else if (bus.lvl_sw[1]) req_page = PAGE_LVL2;
      else if (bus.lvl_sw[2]) req_page = PAGE_LVL3;
   end

   // Next state: a mode change wins; otherwise letters are scored before the tick.
   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      idx_d    = idx_q;
      lives_d  = lives_q;
      time_d   = time_q;
      won_d    = 1'b0;
      finished = 1'b0;
      if (req_page != mode_page(state_q, level_q)) begin
         idx_d   = 4'd0;
         lives_d = LIVES_INIT;
         time_d  = TIME_INIT;
         case (req_page)
            PAGE_START:    state_d = ST_START;
            PAGE_PRACTICE: state_d = ST_PRACTICE;
            PAGE_LVL2:     begin state_d = ST_PLAY; level_d = 2'd2; end
            PAGE_LVL3:     begin state_d = ST_PLAY; level_d = 2'd3; end
            default:       begin state_d = ST_PLAY; level_d = 2'd1; end
         endcase
      end else begin
         case (state_q)
            ST_PRACTICE: begin
               if (bus.letter_valid) idx_d = idx_q + 4'd1;
            end
            ST_PLAY: begin
               if (bus.letter_valid) begin
                  if (bus.letter == rom_char) begin
                     if (idx_q == rom_len - 4'd1) begin
                        state_d  = ST_DONE;
                        won_d    = 1'b1;
                        idx_d    = rom_len;
                        finished = 1'b1;
                     end else begin
                        idx_d = idx_q + 4'd1;
                     end
                  end else begin
                     idx_d = 4'd0;
                     if (lives_q == 2'd1) begin
                        lives_d = 2'd0;
                        state_d = ST_FAIL;
                     end else begin
                        lives_d = lives_q - 2'd1;
                     end
                  end
               end
               // A completing letter freezes the clock at its pre-tick value.
               if (bus.sec_tick && !finished) begin
                  if (time_q == 8'd1) begin
                     time_d  = 8'd0;
                     state_d = ST_FAIL;
                  end else begin
                     time_d = time_q - 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State and output registers; page_sel is decoded from the next state so it tracks state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_START;
         level_q <= 2'd1;
         idx_q   <= 4'd0;
         lives_q <= LIVES_INIT;
         time_q  <= TIME_INIT;
         won_q   <= 1'b0;
         page_q  <= PAGE_START;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         idx_q   <= idx_d;
         lives_q <= lives_d;
         time_q  <= time_d;
         won_q   <= won_d;
         page_q  <= page_decode(state_d, level_d);
      end
   end

   assign bus.page_sel   = page_q;
   assign bus.letter_idx = idx_q;
   assign bus.lives_left = lives_q;
   assign bus.time_left  = time_q;
   assign bus.level_won  = won_q;

endmodule

// File: tb/tb_level_sequencer.sv
// tb/tb_level_sequencer.sv - table, directed and randomized model checks of level_sequencer
module tb_level_sequencer;

   logic clk = 1'b0;
   logic reset_a, reset_b;
   always #5 clk = ~clk;

   level_sequencer_if bus_a ();
   level_sequencer_if bus_b ();

   level_sequencer #(.TIME_LIMIT(60), .LIVES(3)) dut_a (.clk(clk), .reset(reset_a), .bus(bus_a));
   level_sequencer #(.TIME_LIMIT(3),  .LIVES(1)) dut_b (.clk(clk), .reset(reset_b), .bus(bus_b));

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic       rst;
      logic       pr;
      logic [2:0] sw;
      logic       lv;
      logic [7:0] ch;
      logic       tk;
      int         page;
      int         idx;
      int         lives;
      int         tleft;
      int         won;
   } vec_t;

   vec_t  tbl[$];
   string words[4];
   int    tl_p[2] = '{60, 3};
   int    lv_p[2] = '{3, 1};
   int    m_page[2], m_level[2], m_idx[2], m_lives[2], m_time[2], m_won[2];

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_dut(input int d, input string tag, input int page, input int idx,
                            input int lives, input int tleft, input int won);
      if (d == 0) begin
         check({tag, " page_a"},  32'(bus_a.page_sel),   page);
         check({tag, " idx_a"},   32'(bus_a.letter_idx), idx);
         check({tag, " lives_a"}, 32'(bus_a.lives_left), lives);
         check({tag, " time_a"},  32'(bus_a.time_left),  tleft);
         check({tag, " won_a"},   32'(bus_a.level_won),  won);
      end else begin
         check({tag, " page_b"},  32'(bus_b.page_sel),   page);
         check({tag, " idx_b"},   32'(bus_b.letter_idx), idx);
         check({tag, " lives_b"}, 32'(bus_b.lives_left), lives);
         check({tag, " time_b"},  32'(bus_b.time_left),  tleft);
         check({tag, " won_b"},   32'(bus_b.level_won),  won);
      end
   endtask

   // Both DUTs see the same stimulus; one clock edge, then outputs settle for sampling.
   task automatic drive(input logic rst, input logic pr, input logic [2:0] sw,
                        input logic lv, input logic [7:0] ch, input logic tk);
      reset_a = rst;             reset_b = rst;
      bus_a.practice = pr;       bus_b.practice = pr;
      bus_a.lvl_sw = sw;         bus_b.lvl_sw = sw;
      bus_a.letter_valid = lv;   bus_b.letter_valid = lv;
      bus_a.letter = ch;         bus_b.letter = ch;
      bus_a.sec_tick = tk;       bus_b.sec_tick = tk;
      @(posedge clk);
      #1;
   endtask

   // Reference: the game rules stated directly on the displayed page number.
   task automatic model_step(input int d, input logic rst, input logic pr, input logic [2:0] sw,
                             input logic lv, input logic [7:0] ch, input logic tk);
      int req, cur;
      bit fin;
      m_won[d] = 0;
      req = pr ? 1 : sw[0] ? 2 : sw[1] ? 3 : sw[2] ? 4 : 0;
      cur = (m_page[d] <= 1) ? m_page[d] : m_level[d] + 1;
      if (rst) begin
         m_page[d] = 0; m_idx[d] = 0; m_lives[d] = lv_p[d]; m_time[d] = tl_p[d];
      end else if (req != cur) begin
         m_page[d] = req;
         if (req >= 2) m_level[d] = req - 1;
         m_idx[d] = 0; m_lives[d] = lv_p[d]; m_time[d] = tl_p[d];
      end else if (m_page[d] == 1) begin
         if (lv) m_idx[d] = (m_idx[d] + 1) % 16;
      end else if (m_page[d] >= 2 && m_page[d] <= 4) begin
         fin = 0;
         if (lv) begin
            if (ch == words[m_level[d]][m_idx[d]]) begin
               m_idx[d]++;
               if (m_idx[d] == words[m_level[d]].len()) begin
                  m_page[d] = 5; m_won[d] = 1; fin = 1;
               end
            end else begin
               m_idx[d] = 0;
               m_lives[d]--;
               if (m_lives[d] == 0) m_page[d] = 6;
            end
         end
         if (tk && !fin) begin
            m_time[d]--;
            if (m_time[d] == 0) m_page[d] = 6;
         end
      end
   endtask

   function automatic logic [7:0] pick_letter(input int d);
      if (m_page[d] >= 2 && m_page[d] <= 4 && m_idx[d] < words[m_level[d]].len()
          && $urandom_range(0, 9) < 7)
         return words[m_level[d]][m_idx[d]];
      if ($urandom_range(0, 4) == 0) return 8'($urandom_range(0, 255));
      return 8'($urandom_range(65, 90));
   endfunction

   initial begin
      logic       r_rst, r_pr, r_lv, r_tk;
      logic [2:0] r_sw;
      logic [7:0] r_ch;
      vec_t       v;

      words[0] = ""; words[1] = "SOS"; words[2] = "HELP"; words[3] = "ESCAPE";

      // rst pr sw lv ch tk | page idx lives time won
      tbl.push_back('{1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 0, 0, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b001, 1'b0, 8'h00, 1'b0, 2, 0, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b001, 1'b1, "S",   1'b0, 2, 1, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b001, 1'b1, "O",   1'b0, 2, 2, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b001, 1'b1, "S",   1'b0, 5, 3, 3, 60, 1});
      tbl.push_back('{1'b0, 1'b0, 3'b001, 1'b0, 8'h00, 1'b0, 5, 3, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b001, 1'b1, "S",   1'b1, 5, 3, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b010, 1'b0, 8'h00, 1'b0, 3, 0, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b010, 1'b1, "H",   1'b0, 3, 1, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b010, 1'b1, "X",   1'b0, 3, 0, 2, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b010, 1'b1, "Q",   1'b0, 3, 0, 1, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b010, 1'b1, 8'h35, 1'b0, 6, 0, 0, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b010, 1'b0, 8'h00, 1'b1, 6, 0, 0, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 0, 0, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b110, 1'b0, 8'h00, 1'b0, 3, 0, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b110, 1'b0, 8'h00, 1'b1, 3, 0, 3, 59, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b111, 1'b1, "H",   1'b1, 2, 0, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b1, 3'b111, 1'b0, 8'h00, 1'b0, 1, 0, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b1, 3'b111, 1'b1, "A",   1'b0, 1, 1, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b1, 3'b111, 1'b0, 8'h00, 1'b1, 1, 1, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b000, 1'b1, "S",   1'b0, 0, 0, 3, 60, 0});
      tbl.push_back('{1'b0, 1'b0, 3'b000, 1'b1, "S",   1'b1, 0, 0, 3, 60, 0});

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         drive(v.rst, v.pr, v.sw, v.lv, v.ch, v.tk);
         check_dut(0, $sformatf("tbl%0d", i), v.page, v.idx, v.lives, v.tleft, v.won);
      end

      // Level 3 runs out of time on the short-limit instance.
      drive(1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 3'b100, 1'b0, 8'h00, 1'b0);
      check_dut(1, "timeout_entry", 4, 0, 1, 3, 0);
      for (int i = 1; i <= 3; i++) begin
         drive(1'b0, 1'b0, 3'b100, 1'b0, 8'h00, 1'b1);
         check_dut(1, $sformatf("timeout_tick%0d", i), (i == 3) ? 6 : 4, 0, 1, 3 - i, 0);
      end

      // Final letter and last tick in the same cycle: the word wins.
      drive(1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 3'b001, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 3'b001, 1'b1, "S",   1'b0);
      drive(1'b0, 1'b0, 3'b001, 1'b1, "O",   1'b0);
      for (int i = 0; i < 59; i++) drive(1'b0, 1'b0, 3'b001, 1'b0, 8'h00, 1'b1);
      check_dut(0, "race_pre", 2, 2, 3, 1, 0);
      drive(1'b0, 1'b0, 3'b001, 1'b1, "S", 1'b1);
      check_dut(0, "race_win", 5, 3, 3, 1, 1);

      // Practice interrupts a word; the letter count wraps modulo 16.
      drive(1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 3'b001, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 3'b001, 1'b1, "S",   1'b0);
      drive(1'b0, 1'b0, 3'b001, 1'b1, "O",   1'b0);
      drive(1'b0, 1'b1, 3'b001, 1'b0, 8'h00, 1'b0);
      check_dut(0, "practice_entry", 1, 0, 3, 60, 0);
      for (int i = 0; i < 17; i++) drive(1'b0, 1'b1, 3'b001, 1'b1, 8'($urandom_range(0, 255)), 1'b0);
      check_dut(0, "practice_wrap", 1, 1, 3, 60, 0);

      // Reset in the middle of a level.
      drive(1'b0, 1'b0, 3'b001, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b0, 3'b001, 1'b1, "S",   1'b1);
      drive(1'b0, 1'b0, 3'b001, 1'b1, "O",   1'b0);
      check_dut(0, "midplay", 2, 2, 3, 59, 0);
      drive(1'b1, 1'b0, 3'b001, 1'b1, "S", 1'b1);
      check_dut(0, "midplay_reset", 0, 0, 3, 60, 0);

      // Randomized run of both instances against the reference.
      m_level[0] = 1; m_level[1] = 1;
      r_pr = 1'b0; r_sw = 3'b000;
      for (int n = 0; n < 2500; n++) begin
         r_rst = (n == 0) || ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 29) == 0) begin
            r_pr = ($urandom_range(0, 5) == 0);
            r_sw = 3'($urandom_range(0, 7));
         end
         r_lv = 1'($urandom_range(0, 1));
         r_ch = pick_letter($urandom_range(0, 1));
         r_tk = ($urandom_range(0, 3) == 0);
         for (int d = 0; d < 2; d++) model_step(d, r_rst, r_pr, r_sw, r_lv, r_ch, r_tk);
         drive(r_rst, r_pr, r_sw, r_lv, r_ch, r_tk);
         for (int d = 0; d < 2; d++)
            check_dut(d, $sformatf("rand%0d", n), m_page[d], m_idx[d], m_lives[d], m_time[d], m_won[d]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
